// File: rtl/nios_dmem_arb.sv
`default_nettype none
// ============================================================================
// Module   : nios_dmem_arb
// Brief    : Nios2 data-SRAM port controller; core always wins, debug waits
//            via req/gnt with starvation-driven core stall, read data routed
//            back to its owner after the fixed SRAM read latency.
// Revision : 1.0 - initial release
// ============================================================================
module nios_dmem_arb #(
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_rd_i,
    input  logic        core_wr_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    output logic [31:0] core_rdata_o,
    output logic        core_rvalid_o,
    input  logic        dbg_req_i,
    input  logic        dbg_we_i,
    input  logic [31:0] dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    output logic        dbg_gnt_o,
    output logic [31:0] dbg_rdata_o,
    output logic        dbg_rvalid_o,
    output logic        core_stall_o,
    output logic        err_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_STALL = 2'd2
    } state_t;

    localparam logic [7:0] c_MAX_WAIT = 8'(MAX_WAIT);

    state_t              r_state;
    logic [7:0]          r_wait_cnt;
    logic                r_stall;
    logic                r_err;
    logic [RD_LAT-1:0]   r_vld;
    logic [RD_LAT-1:0]   r_own;

    logic                w_core_acc;
    logic                w_dbg_gnt;
    logic                w_mem_en;
    logic                w_mem_we;
    logic [31:0]         w_mem_addr;
    logic [31:0]         w_mem_wdata;
    logic                w_rd_issue;
    logic [7:0]          w_cnt_inc;

    // SRAM command is held quiet while reset is asserted so every output reads 0.
    assign w_core_acc = rst & (core_rd_i | core_wr_i);
    assign w_dbg_gnt  = rst & dbg_req_i & ~(core_rd_i | core_wr_i);

    always_comb begin
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = 32'd0;
        w_mem_wdata = 32'd0;
        if (w_core_acc) begin
            w_mem_en    = 1'b1;
            w_mem_we    = core_wr_i;
            w_mem_addr  = core_addr_i;
            w_mem_wdata = core_wdata_i;
        end else if (w_dbg_gnt) begin
            w_mem_en    = 1'b1;
            w_mem_we    = dbg_we_i;
            w_mem_addr  = dbg_addr_i;
            w_mem_wdata = dbg_wdata_i;
        end
    end

    assign w_rd_issue = w_mem_en & ~w_mem_we;
    assign w_cnt_inc  = (r_wait_cnt == 8'hFF) ? r_wait_cnt : r_wait_cnt + 8'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 8'd0;
            r_stall    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (core_rd_i && core_wr_i) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (dbg_req_i && w_core_acc) begin
                        r_state    <= S_WAIT;
                        r_wait_cnt <= 8'd1;
                    end
                end
                S_WAIT: begin
                    if (!dbg_req_i || w_dbg_gnt) begin
                        r_state    <= S_IDLE;
                        r_wait_cnt <= 8'd0;
                    end else begin
                        r_wait_cnt <= w_cnt_inc;
                        if (w_cnt_inc >= c_MAX_WAIT) begin
                            r_state <= S_STALL;
                            r_stall <= 1'b1;
                        end
                    end
                end
                S_STALL: begin
                    // Stall stays up until debug is served or gives up.
                    if (!dbg_req_i || w_dbg_gnt) begin
                        r_state    <= S_IDLE;
                        r_wait_cnt <= 8'd0;
                        r_stall    <= 1'b0;
                    end else begin
                        r_wait_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_wait_cnt <= 8'd0;
                    r_stall    <= 1'b0;
                end
            endcase
        end
    end

    // Read-return pipeline: owner bit is 1 for debug, 0 for core.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld <= '0;
            r_own <= '0;
        end else begin
            r_vld[0] <= w_rd_issue;
            r_own[0] <= w_dbg_gnt;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_own[i] <= r_own[i-1];
            end
        end
    end

    assign core_rvalid_o = r_vld[RD_LAT-1] & ~r_own[RD_LAT-1];
    assign dbg_rvalid_o  = r_vld[RD_LAT-1] &  r_own[RD_LAT-1];
    assign core_rdata_o  = core_rvalid_o ? mem_rdata_i : 32'd0;
    assign dbg_rdata_o   = dbg_rvalid_o  ? mem_rdata_i : 32'd0;

    assign dbg_gnt_o    = w_dbg_gnt;
    assign core_stall_o = r_stall;
    assign err_o        = r_err;
    assign mem_en_o     = w_mem_en;
    assign mem_we_o     = w_mem_we;
    assign mem_addr_o   = w_mem_addr;
    assign mem_wdata_o  = w_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_nios_dmem_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios_dmem_arb
// Brief    : Directed bench; u_dut2 uses RD_LAT=2, u_dut3 uses RD_LAT=3,
//            both MAX_WAIT=4, sharing every input.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nios_dmem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_rd, core_wr, dbg_req, dbg_we;
    logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata, mem_rdata;

    logic [31:0] c2_rdata, d2_rdata, m2_addr, m2_wdata;
    logic        c2_rvalid, d2_rvalid, g2, st2, e2, en2, we2;
    logic [31:0] c3_rdata, d3_rdata, m3_addr, m3_wdata;
    logic        c3_rvalid, d3_rvalid, g3, st3, e3, en3, we3;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    nios_dmem_arb #(.RD_LAT(2), .MAX_WAIT(4)) u_dut2 (
        .clk(clk), .rst(rst),
        .core_rd_i(core_rd), .core_wr_i(core_wr), .core_addr_i(core_addr),
        .core_wdata_i(core_wdata), .core_rdata_o(c2_rdata), .core_rvalid_o(c2_rvalid),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
        .dbg_wdata_i(dbg_wdata), .dbg_gnt_o(g2), .dbg_rdata_o(d2_rdata),
        .dbg_rvalid_o(d2_rvalid), .core_stall_o(st2), .err_o(e2),
        .mem_en_o(en2), .mem_we_o(we2), .mem_addr_o(m2_addr),
        .mem_wdata_o(m2_wdata), .mem_rdata_i(mem_rdata)
    );

    nios_dmem_arb #(.RD_LAT(3), .MAX_WAIT(4)) u_dut3 (
        .clk(clk), .rst(rst),
        .core_rd_i(core_rd), .core_wr_i(core_wr), .core_addr_i(core_addr),
        .core_wdata_i(core_wdata), .core_rdata_o(c3_rdata), .core_rvalid_o(c3_rvalid),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
        .dbg_wdata_i(dbg_wdata), .dbg_gnt_o(g3), .dbg_rdata_o(d3_rdata),
        .dbg_rvalid_o(d3_rvalid), .core_stall_o(st3), .err_o(e3),
        .mem_en_o(en3), .mem_we_o(we3), .mem_addr_o(m3_addr),
        .mem_wdata_o(m3_wdata), .mem_rdata_i(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after the rising edge; checks land mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #3;
    endtask

    initial begin
        rst = 1'b0;
        core_rd = 0; core_wr = 0; dbg_req = 0; dbg_we = 0;
        core_addr = 0; core_wdata = 0; dbg_addr = 0; dbg_wdata = 0; mem_rdata = 0;
        #2;
        chk("rst_en",     {31'd0, en2}, 0);
        chk("rst_stall",  {31'd0, st2}, 0);
        chk("rst_err",    {31'd0, e2}, 0);
        chk("rst_rvalid", {30'd0, c2_rvalid, d2_rvalid}, 0);
        tick(); tick();
        rst = 1'b1;

        // Core read: cycle 0 issue, RD_LAT=2 return in cycle 2, RD_LAT=3 in cycle 3
        core_rd = 1; core_addr = 32'h10; mem_rdata = 32'hCAFE; mid();
        chk("crd_en",   {31'd0, en2}, 1);
        chk("crd_we",   {31'd0, we2}, 0);
        chk("crd_addr", m2_addr, 32'h10);
        tick(); core_rd = 0; mid();
        chk("crd_c1_rvalid", {31'd0, c2_rvalid}, 0);
        tick(); mid();
        chk("crd_rvalid2", {31'd0, c2_rvalid}, 1);
        chk("crd_rdata2",  c2_rdata, 32'hCAFE);
        chk("crd_dbgrv2",  {31'd0, d2_rvalid}, 0);
        chk("crd_dbgrd2",  d2_rdata, 0);
        chk("crd_rvalid3_early", {31'd0, c3_rvalid}, 0);
        tick(); mid();
        chk("crd_rvalid3", {31'd0, c3_rvalid}, 1);
        chk("crd_rdata3",  c3_rdata, 32'hCAFE);
        chk("crd_rvalid2_gone", {31'd0, c2_rvalid}, 0);
        chk("crd_rdata2_zero",  c2_rdata, 0);

        // Idle debug write: granted in the same cycle
        tick(); dbg_req = 1; dbg_we = 1; dbg_addr = 32'h20; dbg_wdata = 32'h55; mid();
        chk("dwr_gnt",   {31'd0, g2}, 1);
        chk("dwr_we",    {31'd0, we2}, 1);
        chk("dwr_addr",  m2_addr, 32'h20);
        chk("dwr_wdata", m2_wdata, 32'h55);
        tick(); dbg_req = 0; mid();
        chk("idle_en",   {31'd0, en2}, 0);
        chk("idle_addr", m2_addr, 0);
        chk("idle_gnt",  {31'd0, g2}, 0);

        // Collision: core write wins, debug read granted next free cycle
        tick();
        core_wr = 1; core_addr = 32'h30; core_wdata = 32'h77;
        dbg_req = 1; dbg_we = 0; dbg_addr = 32'h40; mid();
        chk("col_we",   {31'd0, we2}, 1);
        chk("col_addr", m2_addr, 32'h30);
        chk("col_gnt",  {31'd0, g2}, 0);
        tick(); core_wr = 0; mid();
        chk("col_gnt2",  {31'd0, g2}, 1);
        chk("col_we2",   {31'd0, we2}, 0);
        chk("col_addr2", m2_addr, 32'h40);
        tick(); dbg_req = 0; mem_rdata = 32'hBEEF; mid();
        chk("col_dbgrv_early", {31'd0, d2_rvalid}, 0);
        tick(); mid();
        chk("col_dbgrv",    {31'd0, d2_rvalid}, 1);
        chk("col_dbgrd",    d2_rdata, 32'hBEEF);
        chk("col_corerv",   {31'd0, c2_rvalid}, 0);
        chk("col_corerd",   c2_rdata, 0);
        chk("col_nostall",  {31'd0, st2}, 0);

        // Starvation with MAX_WAIT=4
        tick(); tick();
        core_rd = 1; core_addr = 32'h50; dbg_req = 1; dbg_we = 0; dbg_addr = 32'h60;
        mid(); chk("stv_c0_gnt", {31'd0, g2}, 0);
        tick(); tick(); tick(); mid();
        chk("stv_c3_stall", {31'd0, st2}, 0);
        tick(); mid();
        chk("stv_c4_stall", {31'd0, st2}, 1);
        chk("stv_c4_gnt",   {31'd0, g2}, 0);
        tick(); core_rd = 0; mid();
        chk("stv_gnt",       {31'd0, g2}, 1);
        chk("stv_gnt_stall", {31'd0, st2}, 1);
        chk("stv_gnt_addr",  m2_addr, 32'h60);
        tick(); dbg_req = 0; mid();
        chk("stv_release", {31'd0, st2}, 0);

        // Abort: blocked request dropped, no SRAM access follows
        tick(); tick(); tick();
        core_rd = 1; core_addr = 32'h90; dbg_req = 1; mid();
        tick(); core_rd = 0; dbg_req = 0; mid();
        chk("abort_en",  {31'd0, en2}, 0);
        chk("abort_gnt", {31'd0, g2}, 0);
        tick(); dbg_req = 1; dbg_we = 1; dbg_addr = 32'hA0; mid();
        chk("abort_regnt", {31'd0, g2}, 1);
        tick(); dbg_req = 0;

        // Both strobes: write issued, sticky error
        tick(); tick(); tick();
        core_rd = 1; core_wr = 1; core_addr = 32'h70; mid();
        chk("both_we",      {31'd0, we2}, 1);
        chk("both_err_pre", {31'd0, e2}, 0);
        tick(); core_rd = 0; core_wr = 0; mid();
        chk("both_err", {31'd0, e2}, 1);
        tick(); tick(); mid();
        chk("both_err_held", {31'd0, e2}, 1);

        // Reset one cycle after a read issue on the RD_LAT=3 instance
        tick(); core_rd = 1; core_addr = 32'h80; mem_rdata = 32'h1234; mid();
        chk("rmr_en", {31'd0, en3}, 1);
        tick(); core_rd = 0; rst = 1'b0; mid();
        chk("rmr_err",    {31'd0, e3}, 0);
        chk("rmr_rvalid", {30'd0, c3_rvalid, d3_rvalid}, 0);
        chk("rmr_stall",  {31'd0, st3}, 0);
        chk("rmr_en0",    {31'd0, en3}, 0);
        tick(); rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mid();
            chk("rmr_no_rvalid3", {30'd0, c3_rvalid, d3_rvalid}, 0);
            chk("rmr_no_rvalid2", {30'd0, c2_rvalid, d2_rvalid}, 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nios_dmem_arb.md
# nios_dmem_arb

Data-memory port controller for the Nios2 core. It shares one single-port synchronous data SRAM between the core's memory stage and a debug/loader requester. The core cannot be back-pressured, so it always wins. The debug port uses a req/gnt handshake, with a starvation counter that requests a core stall when debug waits too long. The block also returns read data to the right owner after the fixed SRAM read latency.

## Interface
Parameters:
- RD_LAT, 1, SRAM read latency in cycles from the enable cycle to data valid on mem_rdata_i; legal range 1..4.
- MAX_WAIT, 8, number of consecutive non-granted debug-request cycles before core_stall_o is raised; legal range 2..255.

Ports (reset rst, asynchronous, active-low; clock clk):
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- core_rd_i  in  1  core memory-stage read strobe, single cycle per access
- core_wr_i  in  1  core memory-stage write strobe
- core_addr_i  in  32  core address
- core_wdata_i  in  32  core write data
- core_rdata_o  out  32  read data to core; 0 when core_rvalid_o is low
- core_rvalid_o  out  1  core read data valid, one-cycle pulse
- dbg_req_i  in  1  debug request; held with we/addr/wdata stable until dbg_gnt_o
- dbg_we_i  in  1  debug access is a write (1) or a read (0)
- dbg_addr_i  in  32  debug address
- dbg_wdata_i  in  32  debug write data
- dbg_gnt_o  out  1  one-cycle pulse in the cycle the debug access is driven to the SRAM
- dbg_rdata_o  out  32  read data to debug; 0 when dbg_rvalid_o is low
- dbg_rvalid_o  out  1  debug read data valid, one-cycle pulse
- core_stall_o  out  1  registered request to deassert the core's enable
- err_o  out  1  sticky: core_rd_i and core_wr_i were both high in the same cycle
- mem_en_o  out  1  SRAM enable
- mem_we_o  out  1  SRAM write enable
- mem_addr_o  out  32  SRAM address
- mem_wdata_o  out  32  SRAM write data
- mem_rdata_i  in  32  SRAM read data

## Operation
- Core access (core_rd_i or core_wr_i high):
  - Passed combinationally to the SRAM in the same cycle: mem_en_o=1, mem_we_o=core_wr_i, address and data from core.
  - If both strobes are high, the access is treated as a write and err_o is set. err_o clears only on reset.
- Debug access:
  - Granted only in a cycle with no core access.
  - In that cycle: SRAM driven from the dbg_* inputs, mem_we_o=dbg_we_i, dbg_gnt_o=1.
  - A new request is eligible the cycle after a grant, so back-to-back debug accesses run at 1 per cycle.
- Idle cycle: mem_en_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
- Read return:
  - RD_LAT-deep shift register of {valid, owner}, loaded on every SRAM read.
  - At the tail, the owner's rvalid pulses and its rdata = mem_rdata_i; the other owner's rdata stays 0.
  - Writes produce no rvalid.
- Arbitration FSM:
  - IDLE: dbg_req_i=1 and no core access → grant, stay in IDLE. dbg_req_i=1 and a core access → WAIT, wait_cnt=1.
  - WAIT: each blocked cycle increments wait_cnt. A grant → IDLE, counter cleared. dbg_req_i dropped → IDLE, counter cleared. wait_cnt reaching MAX_WAIT → STALL.
  - STALL: core_stall_o=1. The grant is taken in the first cycle with no core access (in-flight pipeline ops drain first), then → IDLE and core_stall_o=0. dbg_req_i dropped → IDLE.
- wait_cnt is 8 bits and saturates; it never wraps.

## Timing
- Reset values:
  - All outputs 0.
  - FSM in IDLE, wait_cnt=0, read shift register cleared.
  - Reset mid-read discards the outstanding read; no rvalid appears after reset release.
- SRAM command outputs are combinational from the inputs and FSM state; no added latency.
- Read latency is exactly RD_LAT cycles from the mem_en_o read cycle to the rvalid pulse, for both owners.
- core_stall_o rises on the clock edge where wait_cnt reaches MAX_WAIT and falls on the edge following the grant.
- dbg_req_i dropping without a grant is legal (abort); no SRAM access results.
- A core access and a debug request in the same cycle: the core always wins, in every state.

## Test plan
- Core read, RD_LAT=2: core_rd_i at cycle 0, addr 0x10, SRAM returns 0xCAFE → mem_en_o=1/mem_we_o=0 at cycle 0; core_rvalid_o=1 with core_rdata_o=0xCAFE at cycle 2; dbg_rvalid_o stays 0.
- Idle debug write: dbg_req_i=1, we=1, addr 0x20, wdata 0x55, no core traffic → dbg_gnt_o pulses the same cycle; mem_we_o=1, mem_addr_o=0x20, mem_wdata_o=0x55.
- Collision: core write and debug read in the same cycle → core write issued, no dbg_gnt_o. Debug granted the first free cycle; dbg_rvalid_o RD_LAT cycles later.
- Starvation, MAX_WAIT=4: core accesses every cycle, dbg_req_i held → core_stall_o=1 after 4 blocked cycles. Core traffic stops → grant on the first free cycle; core_stall_o=0 the next cycle.
- Both strobes: core_rd_i=core_wr_i=1 → write issued, err_o=1 and held until rst low.
- Reset mid-read: rst asserted 1 cycle after a read issue (RD_LAT=3) → all outputs 0; no rvalid after release.
